// File: rtl/lsu_pkg.sv
// Shared widths, FSM state encoding and the latched-request record for the
// MEM-stage load/store unit.
package lsu_pkg;

  localparam int A_BITS  = 8;
  localparam int D_BITS  = 16;
  localparam int MEMSIZE = 256;
  localparam int NB      = D_BITS / 8;
  localparam int LB      = $clog2(NB);

  localparam logic [31:0] MEMSIZE_W = 32'(MEMSIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic              write;
    logic              byte_acc;
    logic              sgn;
    logic [A_BITS-1:0] waddr;
    logic [LB-1:0]     lane;
    logic [D_BITS-1:0] wdata;
  } req_t;

  // Word accesses must sit on lane 0, and every access must land inside the array.
  function automatic logic addr_err(input logic              byte_acc,
                                    input logic [LB-1:0]     lane,
                                    input logic [A_BITS-1:0] waddr);
    logic misaligned;
    logic out_of_range;
    misaligned   = !byte_acc && (lane != {LB{1'b0}});
    out_of_range = ({{(32-A_BITS){1'b0}}, waddr} >= MEMSIZE_W);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane datapath: inserts a store byte into a fetched word and extracts
// and extends a load byte from it.
module byte_lane_merge
  import lsu_pkg::*;
(
  input  logic [D_BITS-1:0] word,
  input  logic [LB-1:0]     lane,
  input  logic [7:0]        wbyte,
  input  logic              sgn,
  output logic [D_BITS-1:0] merged,
  output logic [D_BITS-1:0] loaded
);

  logic [7:0] lane_byte_s;

  // Lane insert for read-modify-write stores and lane extract for byte loads.
  always_comb begin
    merged      = word;
    lane_byte_s = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (lane == LB'(i)) begin
        merged[8*i +: 8] = wbyte;
        lane_byte_s      = word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = word[8*i +: 8];
      end
    end
    loaded = {{(D_BITS-8){sgn & lane_byte_s[7]}}, lane_byte_s};
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: accepts one request, sequences mem_read/mem_write
// (with read-modify-write for byte stores) and returns a one-cycle response.
module mem_access_unit
  import lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic               req_byte,
  input  logic               req_signed,
  input  logic [A_BITS+LB-1:0] req_addr,
  input  logic [D_BITS-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [D_BITS-1:0]  rsp_data,
  output logic               mem_read,
  output logic               mem_write,
  output logic [A_BITS-1:0]  mem_address,
  output logic [D_BITS-1:0]  mem_wdata,
  input  logic [D_BITS-1:0]  mem_rdata
);

  state_t            state_r;
  req_t              req_r;
  logic [D_BITS-1:0] merged_s;
  logic [D_BITS-1:0] loaded_s;
  logic [A_BITS-1:0] in_waddr_s;
  logic [LB-1:0]     in_lane_s;

  assign in_waddr_s = req_addr[A_BITS+LB-1:LB];
  assign in_lane_s  = req_addr[LB-1:0];

  byte_lane_merge u_merge (
    .word   (mem_rdata),
    .lane   (req_r.lane),
    .wbyte  (req_r.wdata[7:0]),
    .sgn    (req_r.sgn),
    .merged (merged_s),
    .loaded (loaded_s)
  );

  // Request FSM; every output is a flop so memory strobes never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      req_r       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= {D_BITS{1'b0}};
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= {A_BITS{1'b0}};
      mem_wdata   <= {D_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= {D_BITS{1'b0}};
          if (req_valid) begin
            req_r <= '{write:    req_write,
                       byte_acc: req_byte,
                       sgn:      req_signed,
                       waddr:    in_waddr_s,
                       lane:     in_lane_s,
                       wdata:    req_wdata};
            req_ready <= 1'b0;
            if (addr_err(req_byte, in_lane_s, in_waddr_s)) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!req_write || req_byte) begin
              state_r     <= RD;
              mem_read    <= 1'b1;
              mem_address <= in_waddr_s;
            end else begin
              state_r     <= WR;
              mem_write   <= 1'b1;
              mem_address <= in_waddr_s;
              mem_wdata   <= req_wdata;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          mem_read <= 1'b0;
          if (req_r.write) begin
            state_r   <= WR;
            mem_write <= 1'b1;
            mem_wdata <= merged_s;
          end else begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= req_r.byte_acc ? loaded_s : mem_rdata;
          end
        end
        WR: begin
          // Address and data are left untouched so they stay stable through RESP.
          mem_write <= 1'b0;
          state_r   <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= {D_BITS{1'b0}};
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= {D_BITS{1'b0}};
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit against a small
// level-sensitive word memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255] = '{default: 16'h0000};
  int          wr_count = 0;
  int          rd_count = 0;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_byte    (req_byte),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_data    (rsp_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_address] : 16'h0000;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (mem_write) wr_count <= wr_count + 1;
  end

  always @(posedge clk) begin
    if (mem_read) rd_count <= rd_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for rsp_valid (bounded), then return to IDLE.
  task automatic do_req(input logic wr, input logic by, input logic sg,
                        input logic [8:0] addr, input logic [15:0] wd,
                        output int lat, output logic err, output logic [15:0] data,
                        output logic [7:0] rsp_addr, output logic [15:0] rsp_wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_byte   = by;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      step();
      lat++;
    end
    err      = rsp_err;
    data     = rsp_data;
    rsp_addr = mem_address;
    rsp_wd   = mem_wdata;
    chk("resp_strobes_idle", {30'd0, mem_read, mem_write}, 32'd0);
    step();
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
    chk("valid_drops", {31'd0, rsp_valid}, 32'd0);
  endtask

  int          lat;
  logic        err;
  logic [15:0] data;
  logic [7:0]  raddr;
  logic [15:0] rwd;
  int          wr0;
  int          rd0;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_byte   = 1'b0;
    req_signed = 1'b0;
    req_addr   = 9'h000;
    req_wdata  = 16'h0000;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", {24'd0, mem_address}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_data}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Word store then word load
    wr0 = wr_count; rd0 = rd_count;
    do_req(1'b1, 1'b0, 1'b0, 9'h020, 16'hBEEF, lat, err, data, raddr, rwd);
    chk("wst_lat", lat, 32'd2);
    chk("wst_err", {31'd0, err}, 32'd0);
    chk("wst_data", {16'd0, data}, 32'd0);
    chk("wst_hold_addr", {24'd0, raddr}, 32'h10);
    chk("wst_hold_wdata", {16'd0, rwd}, 32'hBEEF);
    chk("wst_writes", wr_count - wr0, 32'd1);
    chk("wst_reads", rd_count - rd0, 32'd0);
    chk("wst_mem", {16'd0, mem[16]}, 32'hBEEF);

    rd0 = rd_count;
    do_req(1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, lat, err, data, raddr, rwd);
    chk("wld_lat", lat, 32'd2);
    chk("wld_err", {31'd0, err}, 32'd0);
    chk("wld_data", {16'd0, data}, 32'hBEEF);
    chk("wld_reads", rd_count - rd0, 32'd1);

    // Byte store read-modify-write into the upper lane
    wr0 = wr_count; rd0 = rd_count;
    do_req(1'b1, 1'b1, 1'b0, 9'h021, 16'h12A5, lat, err, data, raddr, rwd);
    chk("bst_lat", lat, 32'd3);
    chk("bst_err", {31'd0, err}, 32'd0);
    chk("bst_hold_wdata", {16'd0, rwd}, 32'hA5EF);
    chk("bst_writes", wr_count - wr0, 32'd1);
    chk("bst_reads", rd_count - rd0, 32'd1);
    chk("bst_mem", {16'd0, mem[16]}, 32'hA5EF);

    // Byte loads: signed/unsigned upper lane, signed lower lane
    do_req(1'b0, 1'b1, 1'b1, 9'h021, 16'h0000, lat, err, data, raddr, rwd);
    chk("bld_s_lat", lat, 32'd2);
    chk("bld_s_data", {16'd0, data}, 32'hFFA5);
    do_req(1'b0, 1'b1, 1'b0, 9'h021, 16'h0000, lat, err, data, raddr, rwd);
    chk("bld_u_data", {16'd0, data}, 32'h00A5);
    do_req(1'b0, 1'b1, 1'b1, 9'h020, 16'h0000, lat, err, data, raddr, rwd);
    chk("bld_lane0_data", {16'd0, data}, 32'hFFEF);

    // Misaligned word load
    wr0 = wr_count; rd0 = rd_count;
    do_req(1'b0, 1'b0, 1'b0, 9'h021, 16'h0000, lat, err, data, raddr, rwd);
    chk("mis_lat", lat, 32'd1);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_data", {16'd0, data}, 32'd0);
    chk("mis_no_access", (wr_count - wr0) + (rd_count - rd0), 32'd0);

    // Back-to-back with req_valid held: store 0x1234 to word 0x20, then load it
    wr0 = wr_count;
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 9'h040; req_wdata = 16'h1234;
    step();
    chk("b2b_wr_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_wr_strobe", {31'd0, mem_write}, 32'd1);
    req_write = 1'b0;
    step();
    chk("b2b_resp_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_no_early_read", {31'd0, mem_read}, 32'd0);
    step();
    chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_idle_read", {31'd0, mem_read}, 32'd0);
    step();
    chk("b2b_second_accept", {31'd0, mem_read}, 32'd1);
    chk("b2b_rd_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    step();
    chk("b2b_load_data", {16'd0, rsp_data}, 32'h1234);
    chk("b2b_writes", wr_count - wr0, 32'd1);
    step();

    // Reset during the RD phase of a byte store
    wr0 = wr_count;
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
    req_addr = 9'h020; req_wdata = 16'h0011;
    step();
    chk("abort_in_rd", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_addr", {24'd0, mem_address}, 32'd0);
    chk("abort_wdata", {16'd0, mem_wdata}, 32'd0);
    req_valid = 1'b0;
    step();
    step();
    chk("abort_no_write", wr_count - wr0, 32'd0);
    chk("abort_mem", {16'd0, mem[16]}, 32'hA5EF);
    rst = 1'b0;
    step();
    do_req(1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, lat, err, data, raddr, rwd);
    chk("post_abort_load", {16'd0, data}, 32'hA5EF);
    chk("post_abort_err", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
